vector_pos_stats: RTL and testbench
===================================

Name: vector_pos_stats

Overview:
- Downstream consumer of the registered leading-one detector stage; accepts one 6-bit position code per cycle.
- Accumulates windowed statistics over WINDOW accepted samples: min, max, sum, hit count and truncated average.
- Presents each completed window's result through a one-entry valid/ready output slot for software readout or a logging stage.
- Position encoding: 0..31 = bit index of the detected one, 32 = NONE (all-zero vector), 33..63 = illegal.

Parameters:
- WINDOW, 16, samples per window; power of two, at least 2.
- POS_W, 6, width of the position code.
- NONE_CODE, 32, code meaning "no bit set".
- CNT_W, log2(WINDOW)+1, width of the hit counter; derived, not overridden.
- SUM_W, POS_W+log2(WINDOW), width of the accumulated sum; derived.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- clr  input  1  synchronous window restart; also clears ovf and err.
- in_valid  input  1  pos_in is valid this cycle; there is no backpressure.
- pos_in  input  POS_W  position code from the upstream detector register.
- out_valid  output  1  result slot is full.
- out_ready  input  1  consumer accepts the result.
- out_min  output  POS_W  minimum non-NONE position in the window.
- out_max  output  POS_W  maximum non-NONE position in the window.
- out_sum  output  SUM_W  sum of non-NONE positions.
- out_hits  output  CNT_W  count of non-NONE samples.
- out_avg  output  POS_W  out_sum >> log2(WINDOW), truncated.
- ovf  output  1  sticky flag: a completed window was dropped.
- err  output  1  sticky flag: an illegal code was received.

Behaviour:
- Reset values: all outputs 0. The accumulator is cleared to min=NONE_CODE, max=0, sum=0, hits=0, sample count=0.
- Sample acceptance: a sample is accepted when in_valid=1, clr=0 and rst=0.
- Sample count: increments per accepted sample, including NONE and illegal samples.
- Hit samples (code below NONE_CODE) update:
  - min = smaller of min and pos_in;
  - max = larger of max and pos_in;
  - sum += pos_in;
  - hits += 1.
- NONE and illegal samples: leave min, max, sum and hits unchanged.
- Illegal codes (above NONE_CODE): set err.
- Window completion: the window closes on the cycle its WINDOW-th sample is accepted. The final sample is included in the result. The accumulator reloads to its cleared state on the next edge.
- Result latency: out_valid rises on the edge after completion, i.e. 1 cycle after the last sample's in_valid.
- Empty window (hits=0): out_min=NONE_CODE, out_max=NONE_CODE, out_sum=0, out_avg=0.
- Output slot state machine:
  - EMPTY -> FULL on window completion.
  - FULL -> EMPTY when out_ready=1.
  - FULL -> FULL when out_ready=1 and a window completes in the same cycle: new data is loaded and there is no bubble.
- Output stability: out_* data is held stable while out_valid=1 and out_ready=0.
- Overflow: if a window completes while the slot is FULL and out_ready=0, the new result is discarded, ovf is set, and the pending result is kept.
- clr: sample count and accumulator return to the cleared state; ovf and err are cleared.
  - A sample arriving in the same cycle as clr is discarded.
  - A pending output result is unaffected.
- Width rules:
  - sum cannot overflow: at most (2^POS_W-1)*WINDOW fits in SUM_W bits.
  - hits saturates at WINDOW by construction.
  - Comparisons are unsigned.
- Reset mid-window: all partial state and the pending result are lost.

Decomposition:
- Shared package vector_pos_pkg holds:
  - POS_W, NONE_CODE;
  - typedef pos_t (logic [POS_W-1:0]);
  - function is_hit(pos_t).
- One natural sub-module, pos_window_accum: owns the sample counter and the min/max/sum/hits registers, and emits a done pulse plus the result bundle.
- The top level holds the output slot, the handshake and the sticky flags.

Test Plan:
- Basic window (WINDOW=4, out_ready=1): pos 3,10,32,7 -> one cycle after the 4th sample, out_valid=1, min=3, max=10, sum=20, hits=3, avg=5.
- All-NONE window (WINDOW=4): four samples of 32 -> min=32, max=32, sum=0, hits=0, avg=0, err=0.
- Illegal code (WINDOW=4): 5,40,5,5 -> err=1 from the cycle after 40; result min=5, max=5, sum=15, hits=3.
- Backpressure/overflow (WINDOW=4, out_ready=0): two full windows, first 1,1,1,1 then 9,9,9,9 -> first result held (sum=4), ovf=1. Raising out_ready gives one transfer, then out_valid=0.
- Back-to-back completion (WINDOW=2): slot full, out_ready=1 in the same cycle the next window completes -> out_valid stays 1, data updates to the new window, ovf=0.
- clr mid-window (WINDOW=4): samples 2,4, then clr together with sample 6, then 1,1,1,1 -> result min=1, max=1, sum=4, hits=4; the 2, 4 and 6 samples are absent.

Source files
------------

// File: rtl/vector_pos_stats_pkg.sv
// Shared types for the position statistics path.
// Position codes: 0..31 bit index, 32 none, above that illegal.
package vector_pos_pkg;

  localparam int POS_W     = 6;
  localparam int NONE_CODE = 32;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_e;

  function automatic logic is_hit(pos_t p);
    return p < pos_t'(NONE_CODE);
  endfunction

  function automatic logic is_bad(pos_t p);
    return p > pos_t'(NONE_CODE);
  endfunction

endpackage

// File: rtl/vector_pos_stats_if.sv
// Result slot handshake: one window summary per transfer.
// master drives data/valid, slave drives ready.
interface vector_pos_stats_if
  import vector_pos_pkg::*;
#(
  parameter int WINDOW = 16
);
  localparam int LW    = $clog2(WINDOW);
  localparam int CNT_W = LW + 1;
  localparam int SUM_W = POS_W + LW;

  logic             out_valid;
  logic             out_ready;
  pos_t             out_min;
  pos_t             out_max;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_hits;
  pos_t             out_avg;

  modport master (
    output out_valid, out_min, out_max,
    output out_sum, out_hits, out_avg,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_min, out_max,
    input  out_sum, out_hits, out_avg,
    output out_ready
  );
endinterface

// File: rtl/vector_pos_stats_accum.sv
// Window accumulator: sample counter plus min/max/sum/hits.
// res_* already include the sample closing the window.
module pos_window_accum
  import vector_pos_pkg::*;
#(
  parameter int WINDOW = 16,
  localparam int LW    = $clog2(WINDOW),
  localparam int CNT_W = LW + 1,
  localparam int SUM_W = POS_W + LW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  pos_t             pos_in,
  output logic             done,
  output pos_t             res_min,
  output pos_t             res_max,
  output logic [SUM_W-1:0] res_sum,
  output logic [CNT_W-1:0] res_hits
);

  logic [LW-1:0]    cnt;
  pos_t             mn;
  pos_t             mx;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] hits;

  logic             take;
  logic             hit;
  pos_t             nx_min;
  pos_t             nx_max;
  logic [SUM_W-1:0] nx_sum;
  logic [CNT_W-1:0] nx_hits;

  assign take = in_valid && !clr;
  assign hit  = take && is_hit(pos_in);
  assign done = take && (cnt == LW'(WINDOW - 1));

  assign nx_min  = (hit && pos_in < mn) ? pos_in : mn;
  assign nx_max  = (hit && pos_in > mx) ? pos_in : mx;
  assign nx_sum  = sum + (hit ? SUM_W'(pos_in) : '0);
  assign nx_hits = hits + CNT_W'(hit);

  // An empty window reports NONE for max as well as min.
  assign res_min  = nx_min;
  assign res_max  = (nx_hits == '0) ? pos_t'(NONE_CODE) : nx_max;
  assign res_sum  = nx_sum;
  assign res_hits = nx_hits;

  always_ff @(posedge clk) begin
    if (rst || clr || done) begin
      cnt  <= '0;
      mn   <= pos_t'(NONE_CODE);
      mx   <= '0;
      sum  <= '0;
      hits <= '0;
    end else if (take) begin
      cnt  <= cnt + 1'b1;
      mn   <= nx_min;
      mx   <= nx_max;
      sum  <= nx_sum;
      hits <= nx_hits;
    end
  end

endmodule

// File: rtl/vector_pos_stats.sv
// Windowed statistics over detector position codes.
// One-entry result slot with sticky overflow/illegal flags.
module vector_pos_stats
  import vector_pos_pkg::*;
#(
  parameter int WINDOW = 16,
  localparam int LW    = $clog2(WINDOW),
  localparam int CNT_W = LW + 1,
  localparam int SUM_W = POS_W + LW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  pos_t                pos_in,
  vector_pos_stats_if.master  out,
  output logic                ovf,
  output logic                err
);

  logic             done;
  pos_t             r_min;
  pos_t             r_max;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_hits;

  pos_window_accum #(.WINDOW(WINDOW)) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .pos_in   (pos_in),
    .done     (done),
    .res_min  (r_min),
    .res_max  (r_max),
    .res_sum  (r_sum),
    .res_hits (r_hits)
  );

  slot_e            st;
  slot_e            st_nx;
  logic             load;
  logic             ovf_set;
  pos_t             d_min;
  pos_t             d_max;
  logic [SUM_W-1:0] d_sum;
  logic [CNT_W-1:0] d_hits;

  always_comb begin
    st_nx   = st;
    load    = 1'b0;
    ovf_set = 1'b0;
    unique case (st)
      SLOT_EMPTY: begin
        if (done) begin
          st_nx = SLOT_FULL;
          load  = 1'b1;
        end
      end
      SLOT_FULL: begin
        // Drain and refill in one edge keeps the stream bubble-free.
        if (out.out_ready) begin
          st_nx = done ? SLOT_FULL : SLOT_EMPTY;
          load  = done;
        end else if (done) begin
          ovf_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= SLOT_EMPTY;
      d_min  <= '0;
      d_max  <= '0;
      d_sum  <= '0;
      d_hits <= '0;
    end else begin
      st <= st_nx;
      if (load) begin
        d_min  <= r_min;
        d_max  <= r_max;
        d_sum  <= r_sum;
        d_hits <= r_hits;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (ovf_set)
        ovf <= 1'b1;
      if (in_valid && is_bad(pos_in))
        err <= 1'b1;
    end
  end

  assign out.out_valid = (st == SLOT_FULL);
  assign out.out_min   = d_min;
  assign out.out_max   = d_max;
  assign out.out_sum   = d_sum;
  assign out.out_hits  = d_hits;
  assign out.out_avg   = POS_W'(d_sum >> LW);

endmodule

// File: tb/tb_vector_pos_stats.sv
// Scoreboard bench for vector_pos_stats with a 4-sample window.
// Reference model predicts slot state, flags and results.
module tb_vector_pos_stats;
  import vector_pos_pkg::*;

  localparam int WINDOW = 4;
  localparam int LW     = 2;
  localparam int CNT_W  = 3;
  localparam int SUM_W  = 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic in_valid;
  pos_t pos_in;
  logic ovf;
  logic err;

  vector_pos_stats_if #(.WINDOW(WINDOW)) bus ();

  vector_pos_stats #(.WINDOW(WINDOW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .pos_in   (pos_in),
    .out      (bus.master),
    .ovf      (ovf),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    pos_t             mn;
    pos_t             mx;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] hits;
    pos_t             avg;
  } res_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int m_cnt, m_min, m_max, m_sum, m_hits;
  bit m_full, m_ovf, m_err;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic m_clear();
    m_cnt  = 0;
    m_min  = NONE_CODE;
    m_max  = 0;
    m_sum  = 0;
    m_hits = 0;
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(bit v, int p, bit c, bit r);
    bit   done;
    res_t e;
    in_valid      = v;
    pos_in        = pos_t'(p);
    clr           = c;
    bus.out_ready = r;
    done = 1'b0;
    e    = '0;
    if (c) begin
      m_clear();
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else if (v) begin
      if (p > NONE_CODE) m_err = 1'b1;
      if (p < NONE_CODE) begin
        if (p < m_min) m_min = p;
        if (p > m_max) m_max = p;
        m_sum  += p;
        m_hits += 1;
      end
      m_cnt++;
      if (m_cnt == WINDOW) begin
        done   = 1'b1;
        e.mn   = pos_t'(m_min);
        e.mx   = pos_t'(m_hits == 0 ? NONE_CODE : m_max);
        e.sum  = SUM_W'(m_sum);
        e.hits = CNT_W'(m_hits);
        e.avg  = pos_t'(m_sum >> LW);
        m_clear();
      end
    end
    if (done) begin
      if (!m_full || r) begin
        sb.push_back(e);
        m_full = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_full && r) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic window4(int a, int b, int c, int d, bit r);
    step(1'b1, a, 1'b0, r);
    step(1'b1, b, 1'b0, r);
    step(1'b1, c, 1'b0, r);
    step(1'b1, d, 1'b0, r);
  endtask

  // A transfer happens at the coming edge: compare slot contents now.
  always @(negedge clk) begin
    res_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_min", 32'(bus.out_min), 32'(e.mn));
        chk("out_max", 32'(bus.out_max), 32'(e.mx));
        chk("out_sum", 32'(bus.out_sum), 32'(e.sum));
        chk("out_hits", 32'(bus.out_hits), 32'(e.hits));
        chk("out_avg", 32'(bus.out_avg), 32'(e.avg));
      end
    end
  end

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    in_valid      = 1'b0;
    pos_in        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_min", 32'(bus.out_min), 32'd0);
    chk("rst_max", 32'(bus.out_max), 32'd0);
    chk("rst_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_hits", 32'(bus.out_hits), 32'd0);
    chk("rst_avg", 32'(bus.out_avg), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    m_clear();
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_err  = 1'b0;

    // basic window, then all-NONE window
    window4(3, 10, 32, 7, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    window4(32, 32, 32, 32, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // illegal code sets err, then clr wipes it
    window4(5, 40, 5, 5, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);

    // backpressure: second window dropped, first kept
    window4(1, 1, 1, 1, 1'b0);
    window4(9, 9, 9, 9, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);

    // drain and refill on the same edge
    window4(2, 2, 2, 2, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 31, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // clr mid-window discards earlier and same-cycle samples
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 4, 1'b0, 1'b1);
    step(1'b1, 6, 1'b1, 1'b1);
    window4(1, 1, 1, 1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 63)),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)));
    end

    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
